// File: rtl/tile_stream_writer.sv
// Collects M x m output tiles into an M x WO line memory, then drains the frame
// as a row-major byte stream with valid/ready handshaking.
module tile_stream_writer #(
  parameter int M  = 3,
  parameter int WO = 8,
  parameter int m  = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [M*m*8-1:0]  i_tile,
  input  logic              i_tile_valid,
  output logic              o_tile_ready,
  output logic [7:0]        o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_frame_done
);

  // state   | meaning
  // S_FILL  | accepting tiles into the line memory
  // S_DRAIN | streaming bytes out, tile input stalled
  // S_DONE  | one-cycle frame-done pulse, may accept tile 0 of next frame
  typedef enum logic [1:0] {S_FILL, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(WO + 1);
  localparam int RW = $clog2(M + 1);
  localparam int AW = $clog2(M * WO);

  generate
    if (WO % m != 0) begin : g_bad_geometry
      $error("tile_stream_writer: WO must be a multiple of m");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_active;
  logic [CW-1:0]    r_col_ptr;
  logic [RW-1:0]    r_rd_row;
  logic [CW-1:0]    r_rd_col;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic [7:0]       r_mem [M*WO];

  logic             w_tile_hs;
  logic             w_col_last;
  logic             w_rd_end;
  logic             w_byte_hs;
  logic [AW-1:0]    w_rd_addr;

  assign w_tile_hs  = i_tile_valid & o_tile_ready;
  assign w_col_last = (r_col_ptr == CW'(WO - m));
  assign w_rd_end   = (r_rd_row == RW'(M));
  assign w_byte_hs  = r_data_valid & i_data_ready;
  assign w_rd_addr  = AW'(r_rd_row) * AW'(WO) + AW'(r_rd_col);

  assign o_data       = r_data;
  assign o_data_valid = r_data_valid;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_FILL;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_tile_hs && w_col_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_byte_hs && w_rd_end) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = (w_tile_hs && w_col_last) ? S_DRAIN : S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // r_active keeps tile_ready low through reset and the release edge itself
  always_comb begin
    o_tile_ready = r_active && ((r_state == S_FILL) || (r_state == S_DONE));
    o_frame_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && w_tile_hs) begin
      for (int i = 0; i < M; i++) begin
        for (int j = 0; j < m; j++) begin
          r_mem[AW'(i * WO + j) + AW'(r_col_ptr)] <= i_tile[((M-1-i)*m*8 + (m-1-j)*8) +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col_ptr    <= '0;
      r_rd_row     <= '0;
      r_rd_col     <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
    end else begin
      if (w_tile_hs) begin
        r_col_ptr <= w_col_last ? '0 : r_col_ptr + CW'(m);
      end
      // Load a new byte when the output register is empty or being consumed
      if (r_state == S_DRAIN && (!r_data_valid || i_data_ready)) begin
        if (w_rd_end) begin
          r_data_valid <= 1'b0;
        end else begin
          r_data       <= r_mem[w_rd_addr];
          r_data_valid <= 1'b1;
          if (r_rd_col == CW'(WO - 1)) begin
            r_rd_col <= '0;
            r_rd_row <= r_rd_row + RW'(1);
          end else begin
            r_rd_col <= r_rd_col + CW'(1);
          end
        end
      end
      if (r_state == S_DONE) begin
        r_rd_row <= '0;
        r_rd_col <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_stream_writer.sv
// Directed bench for tile_stream_writer; expected bytes queued at stimulus time,
// compared by an independent negedge monitor.
module tb_tile_stream_writer;
  localparam int M  = 3;
  localparam int WO = 8;
  localparam int TM = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [M*TM*8-1:0] tile;
  logic              tile_valid;
  logic              tile_ready;
  logic [7:0]        data;
  logic              data_valid;
  logic              data_ready;
  logic              frame_done;
  logic              rdy_val;
  logic              rdy_mode;
  logic              tgl = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] q[$];
  int   frame_cnt = 0;
  int   first_acc_cyc = 0;
  int   last_acc_cyc = 0;
  int   done_cyc = 0;
  bit   stall = 1'b0;
  logic [7:0] stall_data = 8'h00;

  int   last_tile_edge = 0;
  int   hs_neg_cyc = 0;
  int   first_tile_neg = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tgl <= ~tgl;

  assign data_ready = rdy_mode ? tgl : rdy_val;

  tile_stream_writer #(.M(M), .WO(WO), .m(TM)) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_tile       (tile),
    .i_tile_valid (tile_valid),
    .o_tile_ready (tile_ready),
    .o_data       (data),
    .o_data_valid (data_valid),
    .i_data_ready (data_ready),
    .o_frame_done (frame_done)
  );

  function automatic void chk(input bit ok, input string nm, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst_n) begin
      q.delete();
      frame_cnt = 0;
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk(data_valid === 1'b1, "stall_valid", int'(data_valid), 1);
        chk(data === stall_data, "stall_data", int'(data), int'(stall_data));
      end
      stall = data_valid && !data_ready;
      stall_data = data;
      if (data_valid && data_ready) begin
        if (q.size() == 0) begin
          chk(1'b0, "unexpected_byte", int'(data), -1);
        end else begin
          exp_b = q.pop_front();
          chk(data === exp_b, "byte", int'(data), int'(exp_b));
        end
        if (frame_cnt == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        frame_cnt++;
      end
      if (frame_done) begin
        chk(frame_cnt == M*WO, "frame_len", frame_cnt, M*WO);
        chk(cyc == last_acc_cyc + 1, "done_latency", cyc - last_acc_cyc, 1);
        done_cyc = cyc;
        frame_cnt = 0;
      end
    end
  end

  task automatic send_tile(input logic [7:0] base, input int k);
    bit got;
    got = 1'b0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < TM; j++)
        tile[((M-1-i)*TM*8 + (TM-1-j)*8) +: 8] = base + 8'(i*WO + k*TM + j);
    tile_valid = 1'b1;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      if (tile_ready) begin
        got = 1'b1;
        hs_neg_cyc = cyc;
        last_tile_edge = cyc + 1;
        @(posedge clk);
        #1;
      end
    end
    if (!got) chk(1'b0, "tile_timeout", 0, 1);
    tile_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap, input int ntiles);
    for (int idx = 0; idx < M*WO; idx++) q.push_back(base + 8'(idx));
    for (int k = 0; k < ntiles; k++) begin
      send_tile(base, k);
      if (k == 0) first_tile_neg = hs_neg_cyc;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    if (!got) chk(1'b0, "done_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    rst_n = 1'b0;
    tile = '0;
    tile_valid = 1'b0;
    rdy_val = 1'b1;
    rdy_mode = 1'b0;

    // 1: reset values, ready one cycle after release
    repeat (3) begin
      @(negedge clk);
      chk(tile_ready === 1'b0, "rst_tile_ready", int'(tile_ready), 0);
      chk(data_valid === 1'b0, "rst_data_valid", int'(data_valid), 0);
      chk(frame_done === 1'b0, "rst_frame_done", int'(frame_done), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk(tile_ready === 1'b0, "ready_release_edge", int'(tile_ready), 0);
    @(negedge clk);
    chk(tile_ready === 1'b1, "ready_after_release", int'(tile_ready), 1);
    @(posedge clk);
    #1;

    // 2: full-rate frame
    send_frame(8'h00, 0, 4);
    wait_done();
    chk(first_acc_cyc == last_tile_edge + 1, "first_byte_latency",
        first_acc_cyc - last_tile_edge, 1);
    chk(last_acc_cyc - first_acc_cyc == M*WO - 1, "full_rate_span",
        last_acc_cyc - first_acc_cyc, M*WO - 1);

    // 3: toggling downstream ready
    rdy_mode = 1'b1;
    send_frame(8'h00, 0, 4);
    wait_done();
    rdy_mode = 1'b0;

    // 4: gapped tiles, next frame's tile 0 pending through drain
    send_frame(8'h00, 2, 4);
    send_frame(8'h80, 0, 4);
    chk(first_tile_neg == done_cyc, "pending_tile_in_done", first_tile_neg, done_cyc);
    wait_done();

    // 5: reset mid-drain
    send_frame(8'h00, 0, 4);
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(posedge clk);
      if (frame_cnt == 10) hit = 1'b1;
    end
    if (!hit) chk(1'b0, "tenth_byte_timeout", frame_cnt, 10);
    #1;
    rst_n = 1'b0;
    rdy_val = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(data_valid === 1'b0, "valid_after_reset", int'(data_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_val = 1'b1;
    send_frame(8'h00, 0, 4);
    wait_done();

    // 6: reset mid-fill, fresh frame offset by 0x40
    send_frame(8'h00, 0, 2);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    send_frame(8'h40, 0, 4);
    wait_done();

    chk(q.size() == 0, "queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
